// File: rtl/smol_stream_arbiter.sv
// smol_stream_arbiter: round-robin N:1 stream arbiter that holds each grant until end of packet or MAX_BURST beats
module smol_stream_arbiter #(
    parameter int NREQ = 4,
    parameter int DW = 32,
    parameter int MAX_BURST = 16,
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    s_vld,
    output logic [NREQ-1:0]    s_rdy,
    input  logic [NREQ*DW-1:0] s_data,
    input  logic [NREQ-1:0]    s_last,
    output logic               m_vld,
    input  logic               m_rdy,
    output logic [DW-1:0]      m_data,
    output logic               m_last,
    output logic [IW-1:0]      grant_id,
    output logic               busy
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_nxt;
    logic [IW-1:0] ptr, sel, sel_hi, sel_any;
    logic [7:0] beat_cnt;
    logic [DW-1:0] words [NREQ];
    logic any_vld, hit_hi, beat, last_beat;
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign words[i] = s_data[i*DW +: DW];
    end
    assign any_vld = |s_vld;
    // Circular search from ptr: prefer the lowest requester at or above ptr, else wrap to the lowest overall.
    always_comb begin
        sel_hi = '0;
        sel_any = '0;
        hit_hi = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (s_vld[i]) begin
                sel_any = IW'(i);
                if (i >= int'(ptr)) begin
                    sel_hi = IW'(i);
                    hit_hi = 1'b1;
                end
            end
        end
        sel = hit_hi ? sel_hi : sel_any;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb state_nxt = (state == IDLE) ? (any_vld ? GRANT : IDLE) : (last_beat ? IDLE : GRANT);
    always_comb begin
        busy = (state == GRANT);
        m_vld = busy & s_vld[grant_id];
        m_data = busy ? words[grant_id] : '0;
        m_last = busy & (s_last[grant_id] | (beat_cnt == 8'(MAX_BURST - 1)));
        s_rdy = '0;
        s_rdy[grant_id] = busy & m_rdy;
        beat = m_vld & m_rdy;
        last_beat = beat & m_last;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
        end else if (state == IDLE && any_vld) begin
            grant_id <= sel;
            beat_cnt <= '0;
        end else if (beat) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (m_last) ptr <= (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);
        end
    end
endmodule

// File: tb/tb_smol_stream_arbiter.sv
// tb_smol_stream_arbiter: scenario tasks drive per-requester packet sources; a scoreboard checks every downstream beat
module tb_smol_stream_arbiter;
    logic clk, rst_n, m_vld, m_rdy, m_last, busy;
    logic [3:0] s_vld, s_rdy, s_last;
    logic [127:0] s_data;
    logic [31:0] m_data;
    logic [1:0] grant_id;
    typedef struct packed {logic [1:0] id; logic [31:0] data; logic last;} beat_t;
    beat_t exp_q[$];
    int tests, fails;
    logic [31:0] sd [4][32];
    logic sl [4][32];
    int sg [4][32];
    int slen[4], spos[4], swait[4];
    logic [3:0] xfer;
    bit src_en;

    smol_stream_arbiter #(.NREQ(4), .DW(32), .MAX_BURST(16)) dut (
        .clk(clk), .rst_n(rst_n), .s_vld(s_vld), .s_rdy(s_rdy), .s_data(s_data), .s_last(s_last),
        .m_vld(m_vld), .m_rdy(m_rdy), .m_data(m_data), .m_last(m_last), .grant_id(grant_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sources advance after the edge on which their beat was accepted; the scoreboard samples at negedge.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            xfer = s_vld & s_rdy;
            if (rst_n && m_vld && m_rdy) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL beat_unexpected: got id=%0d data=%h last=%b, required no beat", grant_id, m_data, m_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({grant_id, m_data, m_last} !== e || !$onehot(s_rdy)) begin
                        fails++;
                        $display("FAIL beat: got id=%0d data=%h last=%b s_rdy=%b, required id=%0d data=%h last=%b one-hot s_rdy",
                                 grant_id, m_data, m_last, s_rdy, e.id, e.data, e.last);
                    end
                end
            end
            @(posedge clk);
            #1;
            if (src_en) begin
                for (int i = 0; i < 4; i++) begin
                    if (xfer[i]) begin
                        spos[i]++;
                        swait[i] = 0;
                    end
                    if (spos[i] < slen[i] && swait[i] >= sg[i][spos[i]]) begin
                        s_vld[i] = 1'b1;
                        s_data[i*32 +: 32] = sd[i][spos[i]];
                        s_last[i] = sl[i][spos[i]];
                    end else begin
                        if (spos[i] < slen[i]) swait[i]++;
                        s_vld[i] = 1'b0;
                        s_data[i*32 +: 32] = 32'hDEAD_0000 | 32'(i);
                        s_last[i] = 1'b1;
                    end
                end
            end
        end
    end

    function automatic bit src_done();
        for (int i = 0; i < 4; i++) if (spos[i] < slen[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_sources();
        for (int i = 0; i < 4; i++) begin
            slen[i] = 0;
            spos[i] = 0;
            swait[i] = 0;
        end
        exp_q.delete();
    endtask

    task automatic load(input int r, input int n, input logic [31:0] base, input logic [31:0] lmask,
                        input int gap_at, input int gap_n);
        for (int p = 0; p < n; p++) begin
            sd[r][p] = base + 32'(p);
            sl[r][p] = lmask[p];
            sg[r][p] = (p == gap_at) ? gap_n : 0;
        end
        slen[r] = n;
        spos[r] = 0;
        swait[r] = 0;
    endtask

    task automatic push(input logic [1:0] id, input logic [31:0] data, input logic last);
        exp_q.push_back('{id: id, data: data, last: last});
    endtask

    task automatic apply_reset();
        src_en = 1'b1;
        rst_n = 1'b0;
        m_rdy = 1'b1;
        clear_sources();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && src_done()) && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!(exp_q.size() == 0 && src_done())) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: %0d beats still expected after %0d cycles, required 0", name, exp_q.size(), budget);
        end
    endtask

    task automatic test_reset();
        src_en = 1'b0;
        s_vld = 4'hF;
        s_last = 4'hF;
        s_data = {$urandom, $urandom, $urandom, $urandom};
        m_rdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #2;
            tests++;
            if ({busy, m_vld, s_rdy, m_last, m_data, grant_id} !== 40'd0) begin
                fails++;
                $display("FAIL reset_outputs: got busy=%b m_vld=%b s_rdy=%b m_last=%b m_data=%h grant_id=%0d, required all 0",
                         busy, m_vld, s_rdy, m_last, m_data, grant_id);
            end
        end
        s_vld = '0;
        s_last = '0;
        src_en = 1'b1;
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #2;
            tests++;
            if (busy !== 1'b0 || s_rdy !== 4'b0) begin
                fails++;
                $display("FAIL idle_no_request: got busy=%b s_rdy=%b, required busy=0 s_rdy=0000", busy, s_rdy);
            end
        end
    endtask

    task automatic test_single();
        apply_reset();
        load(2, 3, 32'hA0, 32'b100, -1, 0);
        push(2, 32'hA0, 0);
        push(2, 32'hA1, 0);
        push(2, 32'hA2, 1);
        @(posedge clk);
        #2;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL single_arb_cycle: got busy=%b, required 0", busy);
        end
        @(posedge clk);
        #2;
        tests++;
        if (busy !== 1'b1 || grant_id !== 2'd2 || m_vld !== 1'b1 || m_data !== 32'hA0) begin
            fails++;
            $display("FAIL single_grant: got busy=%b grant_id=%0d m_vld=%b m_data=%h, required 1 2 1 000000a0",
                     busy, grant_id, m_vld, m_data);
        end
        wait_drain("single", 20);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL single_release: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_round_robin();
        int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        apply_reset();
        for (int i = 0; i < 4; i++) load(i, 2, 32'hB000_0000 + 32'(i * 16), 32'b11, -1, 0);
        for (int p = 0; p < 2; p++) for (int i = 0; i < 4; i++) push(2'(i), 32'hB000_0000 + 32'(i * 16 + p), 1'b1);
        @(posedge clk);
        #2;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #2;
            tests++;
            if (busy !== 1'(k % 2) || (busy && grant_id !== 2'(order[(k - 1) / 2]))) begin
                fails++;
                $display("FAIL rr_cycle%0d: got busy=%b grant_id=%0d, required busy=%0d grant_id=%0d",
                         k, busy, grant_id, k % 2, order[(k - 1) / 2]);
            end
        end
        wait_drain("rr", 10);
    endtask

    task automatic test_max_burst();
        apply_reset();
        load(1, 20, 32'hC0, 32'b0, -1, 0);
        load(3, 1, 32'h3F, 32'b1, -1, 0);
        for (int p = 0; p < 16; p++) push(1, 32'hC0 + 32'(p), p == 15);
        push(3, 32'h3F, 1);
        for (int p = 16; p < 20; p++) push(1, 32'hC0 + 32'(p), 0);
        wait_drain("burst", 60);
        tests++;
        if (busy !== 1'b1 || grant_id !== 2'd1 || m_vld !== 1'b0) begin
            fails++;
            $display("FAIL burst_hold: got busy=%b grant_id=%0d m_vld=%b, required 1 1 0", busy, grant_id, m_vld);
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] pat = 6'b111001;
        int idx;
        apply_reset();
        load(0, 4, 32'hD0, 32'b1000, -1, 0);
        for (int p = 0; p < 4; p++) push(0, 32'hD0 + 32'(p), p == 3);
        @(posedge clk);
        #2;
        idx = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #2;
            m_rdy = pat[k];
            #1;
            tests++;
            if (s_rdy !== {3'b000, pat[k]} || m_data !== 32'hD0 + 32'(idx)) begin
                fails++;
                $display("FAIL bp_cycle%0d: got s_rdy=%b m_data=%h, required s_rdy=%b m_data=%h",
                         k, s_rdy, m_data, {3'b000, pat[k]}, 32'hD0 + 32'(idx));
            end
            if (pat[k]) idx++;
        end
        m_rdy = 1'b1;
        wait_drain("bp", 10);
    endtask

    task automatic test_reset_mid();
        int n;
        apply_reset();
        load(0, 1, 32'h11, 32'b1, -1, 0);
        load(1, 5, 32'hE0, 32'b10000, -1, 0);
        push(0, 32'h11, 1);
        push(1, 32'hE0, 0);
        push(1, 32'hE1, 0);
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        tests++;
        if (busy !== 1'b1 || grant_id !== 2'd1 || m_data !== 32'hE2) begin
            fails++;
            $display("FAIL rstmid_live: got busy=%b grant_id=%0d m_data=%h, required 1 1 000000e2", busy, grant_id, m_data);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, m_vld, s_rdy, m_last} !== 7'd0) begin
            fails++;
            $display("FAIL rstmid_async: got busy=%b m_vld=%b s_rdy=%b m_last=%b, required all 0", busy, m_vld, s_rdy, m_last);
        end
        clear_sources();
        load(0, 1, 32'h30, 32'b1, -1, 0);
        load(1, 1, 32'h31, 32'b1, -1, 0);
        push(0, 32'h30, 1);
        push(1, 32'h31, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        tests++;
        if (busy !== 1'b1 || grant_id !== 2'd0) begin
            fails++;
            $display("FAIL rstmid_first_grant: got busy=%b grant_id=%0d, required busy=1 grant_id=0", busy, grant_id);
        end
        wait_drain("rstmid", 20);
    endtask

    task automatic test_vld_gap();
        int gaps, n;
        bit early3;
        apply_reset();
        load(0, 4, 32'hF0, 32'b1000, 2, 3);
        load(3, 1, 32'h3F, 32'b1, -1, 0);
        for (int p = 0; p < 4; p++) push(0, 32'hF0 + 32'(p), p == 3);
        push(3, 32'h3F, 1);
        gaps = 0;
        early3 = 1'b0;
        n = 0;
        @(posedge clk);
        #2;
        while (!(exp_q.size() == 0 && !busy) && n < 40) begin
            @(posedge clk);
            #2;
            n++;
            if (busy && !m_vld) gaps++;
            if (busy && grant_id == 2'd3 && spos[0] < slen[0]) early3 = 1'b1;
        end
        tests++;
        if (gaps != 3 || early3) begin
            fails++;
            $display("FAIL gap_hold: got stall_cycles=%0d req3_early=%b, required 3 0", gaps, early3);
        end
        wait_drain("gap", 10);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        src_en = 1'b0;
        m_rdy = 1'b0;
        s_vld = '0;
        s_last = '0;
        s_data = '0;
        for (int i = 0; i < 4; i++) begin
            slen[i] = 0;
            spos[i] = 0;
            swait[i] = 0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_max_burst();
        test_backpressure();
        test_reset_mid();
        test_vld_gap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/smol_stream_arbiter.md
SMOL_STREAM_ARBITER -- requirements
Module: smol_stream_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requester stream ports (2..8).
REQ-002 SHALL have parameter DW, default 32, data width of every stream.
REQ-003 SHALL have parameter MAX_BURST, default 16, max beats per grant (1..255).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port s_vld  input  NREQ  per-requester valid.
REQ-007 SHALL have port s_rdy  output  NREQ  per-requester ready.
REQ-008 SHALL have port s_data  input  NREQ*DW  packed requester data; requester i at bits [i*DW +: DW].
REQ-009 SHALL have port s_last  input  NREQ  per-requester end-of-packet flag.
REQ-010 SHALL have port m_vld  output  1  shared downstream valid.
REQ-011 SHALL have port m_rdy  input  1  shared downstream ready.
REQ-012 SHALL have port m_data  output  DW  shared downstream data.
REQ-013 SHALL have port m_last  output  1  end-of-grant flag to downstream.
REQ-014 SHALL have port grant_id  output  clog2(NREQ)  index of current owner; valid only when busy=1.
REQ-015 SHALL have port busy  output  1  high while a grant is held.

Function
REQ-016 SHALL implement FSM states IDLE and GRANT; state, grant_id, beat counter and priority pointer are registers.
REQ-017 IDLE: m_vld=0, s_rdy=0, busy=0; if any s_vld bit is 1, select lowest index i with s_vld[i]=1 searching circularly from ptr, register grant_id=i, clear beat counter, go to GRANT next cycle.
REQ-018 IDLE with s_vld all zero SHALL remain IDLE with no register change.
REQ-019 GRANT: m_vld=s_vld[grant_id], m_data=s_data[grant_id], s_rdy[grant_id]=m_rdy, all other s_rdy bits 0, busy=1; paths combinational (zero-cycle latency through the mux).
REQ-020 GRANT: m_last SHALL equal s_last[grant_id] OR (beat counter == MAX_BURST-1).
REQ-021 A beat SHALL transfer when m_vld and m_rdy are both 1; beat counter increments by 1 per beat, 8 bits wide, never wraps within a grant.
REQ-022 Beat transferred with m_last=1 SHALL end the grant: next cycle state=IDLE, ptr=(grant_id+1) mod NREQ.
REQ-023 Grant SHALL be held while owner deasserts s_vld mid-packet; no timeout, other requesters stay blocked.
REQ-024 Each grant costs exactly one IDLE cycle before the next grant (no back-to-back re-arbitration).
REQ-025 A requester that was just served SHALL have lowest priority at the next arbitration (round-robin fairness); with all NREQ requesting, each is served once per NREQ grants.
REQ-026 Requester's s_vld rising during another's grant SHALL only be considered at the next IDLE cycle.
REQ-027 Data, last and valid of non-granted requesters SHALL never reach m_*; s_rdy SHALL never have more than one bit set.
REQ-028 MAX_BURST=1 SHALL force m_last=1 on every beat.

Reset
REQ-029 rst_n=0 SHALL immediately (asynchronously) force state=IDLE, ptr=0, grant_id=0, beat counter=0, so busy=0, m_vld=0, s_rdy=0, m_last=0, m_data=0.
REQ-030 Reset asserted mid-grant SHALL abandon the packet without completing it; after rst_n=1, first arbitration starts from ptr=0.
REQ-031 Outputs SHALL be stable from the first rising clk after rst_n deasserts; no beat transfers during reset.

Verification
REQ-032 Single requester: s_vld[2]=1, 3-beat packet 0xA0,0xA1,0xA2 with last on 0xA2, m_rdy=1 -> grant_id=2 one cycle later, 3 beats in order, m_last on 0xA2, back to IDLE next cycle.
REQ-033 All four requesting continuously, 1-beat packets -> grant order 0,1,2,3,0,1 with one IDLE cycle between grants.
REQ-034 Requester 1 sends 20 beats with no s_last, MAX_BURST=16 -> m_last on beat 16, grant ends, requester 1 regains grant after other requesters, remaining 4 beats follow.
REQ-035 Backpressure: m_rdy toggled 1,0,0,1 during a grant -> s_rdy[owner] mirrors m_rdy, beats transfer only when m_rdy=1, data unchanged while stalled, no duplication or loss.
REQ-036 Reset mid-packet at beat 2 of 5 -> busy=0, m_vld=0 same cycle; after release, requester 0 granted first if requesting.
REQ-037 Owner drops s_vld for 3 cycles mid-packet while requester 3 requests -> m_vld=0 for 3 cycles, grant_id unchanged, requester 3 not granted until owner's last beat.
